// File: rtl/mill_rx_pkg.sv
// Shared types and sizing for the Miller-coded receive frame controller.
package mill_rx_pkg;

  localparam int TIMEOUT_DEF   = 20;
  localparam int MAX_BYTES_DEF = 32;
  localparam int POS_W         = 4;   // committed-bit position 0..8
  localparam int CNT_W         = 6;   // received byte count

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_RECV,
    ST_FINISH
  } rx_state_e;

endpackage

// File: rtl/mill_rx_byte_asm.sv
// Byte assembler: LSB-first shift register, bit position and running parity.
// Position 8 means eight data bits are in; the next shifted bit is parity.
module mill_rx_byte_asm
  import mill_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [POS_W-1:0] pos,
  output logic [7:0]       data,
  output logic             byte_done,
  output logic             parity_ok
);

  logic [7:0]       sr_q, sr_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             par_q, par_d;

  // next-state: clear, shift a data bit, or wrap after the parity bit
  always_comb begin
    sr_d  = sr_q;
    pos_d = pos_q;
    par_d = par_q;
    if (clr) begin
      sr_d  = '0;
      pos_d = '0;
      par_d = 1'b0;
    end else if (shift_en) begin
      if (pos_q == POS_W'(8)) begin
        sr_d  = '0;
        pos_d = '0;
        par_d = 1'b0;
      end else begin
        sr_d  = {bit_in, sr_q[7:1]};
        pos_d = pos_q + POS_W'(1);
        par_d = par_q ^ bit_in;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      pos_q <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      pos_q <= pos_d;
      par_q <= par_d;
    end
  end

  assign pos       = pos_q;
  // Bits enter at the MSB, so a partial byte is right-aligned by 8-pos.
  assign data      = sr_q >> (POS_W'(8) - pos_q);
  assign byte_done = shift_en && !clr && (pos_q == POS_W'(8));
  // Odd parity: all nine bits must XOR to 1.
  assign parity_ok = par_q ^ bit_in;

endmodule

// File: rtl/mill_rx_frame_ctrl.sv
// Receive frame controller for Miller-decoded bits: SOF detect, one-bit
// lookahead so the final (EOF) bit is never committed, gap timeout, byte
// delivery with parity and framing checks.
//
// state       | meaning
// ST_IDLE     | decoder off, waiting for arm
// ST_WAIT_SOF | decoder on, waiting for a strobed 0
// ST_RECV     | receiving bits through the lookahead
// ST_FINISH   | one cycle: EOF check, flush partial byte, frame_done
module mill_rx_frame_ctrl
  import mill_rx_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic             clk,
  input  logic             in_rst,
  input  logic             in_arm,
  input  logic             in_abort,
  input  logic             in_bit,
  input  logic             in_bit_valid,
  output logic             out_demod_enable,
  output logic [7:0]       out_byte,
  output logic             out_byte_valid,
  output logic [3:0]       out_last_bits,
  output logic             out_frame_done,
  output logic             out_parity_err,
  output logic             out_frame_err,
  output logic [CNT_W-1:0] out_byte_cnt,
  output logic             out_busy
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  rx_state_e        state_q, state_d;
  logic             held_q, held_d, held_vld_q, held_vld_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic [3:0]       last_q, last_d;
  logic             done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, demod_q, demod_d;
  logic             asm_clr, asm_shift;
  logic [POS_W-1:0] asm_pos;
  logic [7:0]       asm_data;
  logic             asm_done, asm_par_ok;

  mill_rx_byte_asm u_asm (
    .clk       (clk),
    .rst       (in_rst),
    .clr       (asm_clr),
    .shift_en  (asm_shift),
    .bit_in    (held_q),
    .pos       (asm_pos),
    .data      (asm_data),
    .byte_done (asm_done),
    .parity_ok (asm_par_ok)
  );

  // FSM next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    gap_d      = gap_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    last_d     = last_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    cnt_d      = cnt_q;
    asm_clr    = 1'b0;
    asm_shift  = 1'b0;
    if (in_abort) begin
      state_d    = ST_IDLE;
      held_vld_d = 1'b0;
      gap_d      = '0;
      asm_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_arm) begin
            state_d    = ST_WAIT_SOF;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            cnt_d      = '0;
            held_vld_d = 1'b0;
            gap_d      = '0;
            asm_clr    = 1'b1;
          end
        end
        ST_WAIT_SOF: begin
          gap_d = '0;
          if (in_bit_valid && !in_bit) state_d = ST_RECV;
        end
        ST_RECV: begin
          if (in_bit_valid) begin
            gap_d      = '0;
            held_d     = in_bit;
            held_vld_d = 1'b1;
            asm_shift  = held_vld_q;
            if (asm_done) begin
              if (cnt_q == CNT_W'(MAX_BYTES)) begin
                ferr_d  = 1'b1;
                state_d = ST_FINISH;
              end else begin
                byte_vld_d = 1'b1;
                byte_d     = asm_data;
                last_d     = 4'd0;
                cnt_d      = cnt_q + CNT_W'(1);
                if (!asm_par_ok) perr_d = 1'b1;
              end
            end
          end else if (gap_q == GAP_W'(TIMEOUT)) begin
            state_d = ST_FINISH;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        ST_FINISH: begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          if (!held_vld_q || held_q) ferr_d = 1'b1;
          if (asm_pos != '0) begin
            byte_vld_d = 1'b1;
            byte_d     = asm_data;
            last_d     = asm_pos;
            cnt_d      = cnt_q + CNT_W'(1);
          end
          held_vld_d = 1'b0;
          gap_d      = '0;
          asm_clr    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d  = (state_d != ST_IDLE);
    demod_d = (state_d == ST_WAIT_SOF) || (state_d == ST_RECV);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (in_rst) begin
      state_q    <= ST_IDLE;
      held_q     <= 1'b0;
      held_vld_q <= 1'b0;
      gap_q      <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      last_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      demod_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      gap_q      <= gap_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      last_q     <= last_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      demod_q    <= demod_d;
    end
  end

  assign out_demod_enable = demod_q;
  assign out_byte         = byte_q;
  assign out_byte_valid   = byte_vld_q;
  assign out_last_bits    = last_q;
  assign out_frame_done   = done_q;
  assign out_parity_err   = perr_q;
  assign out_frame_err    = ferr_q;
  assign out_byte_cnt     = cnt_q;
  assign out_busy         = busy_q;

endmodule

// File: tb/tb_mill_rx_frame_ctrl.sv
// Bench for mill_rx_frame_ctrl: directed frames plus randomized frames,
// checked against a bit-list model of the framing rules.
module tb_mill_rx_frame_ctrl;

  localparam int TO = 20;
  localparam int MB = 32;

  logic       clk = 1'b0;
  logic       in_rst, in_arm, in_abort, in_bit, in_bit_valid;
  logic       out_demod_enable, out_byte_valid, out_frame_done;
  logic       out_parity_err, out_frame_err, out_busy;
  logic [7:0] out_byte;
  logic [3:0] out_last_bits;
  logic [5:0] out_byte_cnt;

  mill_rx_frame_ctrl #(.TIMEOUT(TO), .MAX_BYTES(MB)) dut (
    .clk              (clk),
    .in_rst           (in_rst),
    .in_arm           (in_arm),
    .in_abort         (in_abort),
    .in_bit           (in_bit),
    .in_bit_valid     (in_bit_valid),
    .out_demod_enable (out_demod_enable),
    .out_byte         (out_byte),
    .out_byte_valid   (out_byte_valid),
    .out_last_bits    (out_last_bits),
    .out_frame_done   (out_frame_done),
    .out_parity_err   (out_parity_err),
    .out_frame_err    (out_frame_err),
    .out_byte_cnt     (out_byte_cnt),
    .out_busy         (out_busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [11:0] mon_q[$];
  logic [11:0] exp_q[$];
  bit          q_bits[$];
  bit          exp_perr, exp_ferr;
  int          exp_cnt;
  bit          arm_noise = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_byte_valid) mon_q.push_back({out_last_bits, out_byte});
    if (out_frame_done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit b, input int space);
    in_bit       = b;
    in_bit_valid = 1'b1;
    if (arm_noise && ($urandom_range(0, 15) == 0)) in_arm = 1'b1;
    cyc();
    in_bit_valid = 1'b0;
    in_arm       = 1'b0;
    repeat (space - 1) cyc();
  endtask

  task automatic add_byte(input logic [7:0] b, input bit flip);
    for (int i = 0; i < 8; i++) q_bits.push_back(b[i]);
    q_bits.push_back((~^b) ^ flip);
  endtask

  // Expected result from the bit list (payload bits followed by EOF).
  task automatic model();
    int n, payload, full, rem, x;
    logic [7:0] v;
    bit dropped;
    exp_q.delete();
    exp_perr = 0; exp_ferr = 0; exp_cnt = 0; dropped = 0;
    n = q_bits.size();
    if (n == 0) begin
      exp_ferr = 1;
    end else begin
      payload = n - 1;
      full    = payload / 9;
      for (int g = 0; g < full && !dropped; g++) begin
        if (exp_cnt == MB) begin
          exp_ferr = 1;
          dropped  = 1;
        end else begin
          x = 0; v = '0;
          for (int i = 0; i < 9; i++) x ^= int'(q_bits[g*9+i]);
          for (int i = 0; i < 8; i++) v[i] = q_bits[g*9+i];
          if (x == 0) exp_perr = 1;
          exp_q.push_back({4'd0, v});
          exp_cnt++;
        end
      end
      if (!dropped) begin
        rem = payload - full * 9;
        if (rem > 0) begin
          v = '0;
          for (int i = 0; i < rem; i++) v[i] = q_bits[full*9+i];
          exp_q.push_back({4'(rem), v});
          exp_cnt++;
        end
        if (q_bits[n-1]) exp_ferr = 1;
      end
    end
  endtask

  // mode 0: ETU spacing, 1: random spacing up to TO+1, 2: always TO+1
  task automatic run_frame(input string nm, input int lead1, input int mode);
    int sp, w;
    mon_q.delete();
    done_cnt = 0;
    model();
    in_arm = 1'b1; cyc(); in_arm = 1'b0; cyc();
    repeat (lead1) strobe(1'b1, 8);
    strobe(1'b0, 8);
    foreach (q_bits[i]) begin
      sp = 8;
      if (mode == 2) sp = TO + 1;
      else if (mode == 1 && $urandom_range(0, 1) == 1) sp = $urandom_range(1, TO + 1);
      strobe(q_bits[i], sp);
    end
    w = 0;
    while (done_cnt == 0 && w < 100) begin cyc(); w++; end
    if (done_cnt == 0) check_val({nm, "_done_timeout"}, 0, 1);
    cyc(); cyc();
    check_val({nm, "_nbytes"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check_val($sformatf("%s_byte%0d", nm, i), mon_q[i], exp_q[i]);
    check_val({nm, "_perr"}, out_parity_err, exp_perr);
    check_val({nm, "_ferr"}, out_frame_err, exp_ferr);
    check_val({nm, "_cnt"}, out_byte_cnt, exp_cnt);
    check_val({nm, "_done"}, done_cnt, 1);
    check_val({nm, "_busy"}, out_busy, 0);
  endtask

  task automatic check_all_zero(input string nm);
    check_val({nm, "_outs"},
              {out_demod_enable, out_byte, out_byte_valid, out_last_bits, out_frame_done,
               out_parity_err, out_frame_err, out_byte_cnt, out_busy}, 0);
  endtask

  initial begin
    int nb;
    in_rst = 1'b1; in_arm = 0; in_abort = 0; in_bit = 0; in_bit_valid = 0;
    cyc(); cyc();
    in_rst = 1'b0;
    cyc();
    check_all_zero("reset");

    // REQA short frame, 7 bits
    q_bits = '{0, 1, 1, 0, 0, 1, 0, 0};
    run_frame("reqa", 0, 0);
    check_val("reqa_last", mon_q.size() > 0 ? mon_q[0][11:8] : 4'hF, 7);

    q_bits.delete(); add_byte(8'h93, 0); add_byte(8'h20, 0); q_bits.push_back(0);
    run_frame("two_bytes", 1, 0);
    q_bits.delete(); add_byte(8'h93, 0); add_byte(8'h20, 1); q_bits.push_back(0);
    run_frame("bad_parity", 0, 2);
    q_bits.delete(); add_byte(8'h5A, 0); q_bits.push_back(1);
    run_frame("eof_one", 0, 0);
    q_bits.delete();
    run_frame("sof_only", 2, 0);

    // abort mid-frame, and abort beating arm in IDLE
    mon_q.delete(); done_cnt = 0;
    in_arm = 1; cyc(); in_arm = 0; cyc();
    strobe(0, 8);
    repeat (5) strobe($urandom_range(0, 1), 8);
    check_val("pre_abort_demod", out_demod_enable, 1);
    check_val("pre_abort_busy", out_busy, 1);
    in_abort = 1; cyc(); in_abort = 0;
    check_val("abort_demod", out_demod_enable, 0);
    check_val("abort_busy", out_busy, 0);
    repeat (40) cyc();
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_no_byte", mon_q.size(), 0);
    in_arm = 1; in_abort = 1; cyc(); in_arm = 0; in_abort = 0;
    check_val("abort_over_arm", out_busy, 0);

    // reset mid-frame after a bad-parity byte
    in_arm = 1; cyc(); in_arm = 0; cyc();
    strobe(0, 8);
    q_bits.delete(); add_byte(8'h20, 1);
    foreach (q_bits[i]) strobe(q_bits[i], 8);
    strobe(1, 8); strobe(0, 3);
    check_val("pre_rst_perr", out_parity_err, 1);
    check_val("pre_rst_cnt", out_byte_cnt, 1);
    in_rst = 1; cyc(); in_rst = 0;
    check_all_zero("mid_rst");
    cyc();

    // overflow: one more byte than allowed
    q_bits.delete();
    for (int i = 0; i < MB + 1; i++) add_byte(8'(i * 7 + 3), 0);
    q_bits.push_back(0);
    run_frame("overflow", 0, 0);

    // randomized frames
    arm_noise = 1'b1;
    for (int f = 0; f < 30; f++) begin
      q_bits.delete();
      if ($urandom_range(0, 9) != 0) begin
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) add_byte(8'($urandom), $urandom_range(0, 4) == 0);
        repeat ($urandom_range(0, 8)) q_bits.push_back($urandom_range(0, 1));
        q_bits.push_back($urandom_range(0, 5) == 0);
      end
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 2), 1);
    end
    arm_noise = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
